// File: rtl/data_mem_arbiter.sv
// Arbiter that shares the single-ported data memory between port A (CPU) and port B (loader).
// Each access runs IDLE -> SERVE -> ACK. Out-of-range addresses get err=1, read data 0, and no write.
module data_mem_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [63:0] DATA_START = 64'h1000_0000_0000_0000,
  parameter logic [63:0] DATA_WORDS = 64'h0000_0000_0010_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_word_we,
  input  logic        a_byte_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [63:0] a_rdata,
  input  logic        b_req,
  input  logic        b_word_we,
  input  logic        b_byte_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [63:0] b_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_word_we,
  output logic        mem_byte_we,
  input  logic [63:0] mem_rdata
);

  localparam logic [63:0] DATA_BYTES = DATA_WORDS << 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_b;
  logic        r_win_b;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_word_we;
  logic        r_byte_we;
  logic [63:0] r_a_rdata;
  logic [63:0] r_b_rdata;
  logic        r_a_err;
  logic        r_b_err;

  logic        w_any_req;
  logic        w_grant_b;
  logic        w_in_range;
  logic [63:0] w_offset;

  assign w_any_req = a_req | b_req;
  // On a tie under round-robin, B wins only when A was the last port granted.
  assign w_grant_b = b_req & (~a_req | (~FIXED_PRIO & ~r_last_b));

  // The lower-bound test comes first, so an address below the segment cannot wrap into range.
  assign w_offset   = r_addr - DATA_START;
  assign w_in_range = (r_addr >= DATA_START) && (w_offset < DATA_BYTES);

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign a_err     = r_a_err;
  assign b_err     = r_b_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    mem_word_we  = 1'b0;
    mem_byte_we  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        mem_word_we  = r_word_we & w_in_range;
        mem_byte_we  = r_byte_we & ~r_word_we & w_in_range;
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        a_ack        = ~r_win_b;
        b_ack        = r_win_b;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b  <= 1'b1;
      r_win_b   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_word_we <= 1'b0;
      r_byte_we <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_win_b   <= w_grant_b;
        r_last_b  <= w_grant_b;
        r_addr    <= w_grant_b ? b_addr : a_addr;
        r_wdata   <= w_grant_b ? b_wdata : a_wdata;
        r_word_we <= w_grant_b ? b_word_we : a_word_we;
        r_byte_we <= w_grant_b ? b_byte_we : a_byte_we;
      end
      // The memory has already written at this cycle's negedge, so a write returns the updated word.
      if (r_state == ST_SERVE) begin
        if (r_win_b) begin
          r_b_rdata <= w_in_range ? mem_rdata : 64'd0;
          r_b_err   <= ~w_in_range;
        end else begin
          r_a_rdata <= w_in_range ? mem_rdata : 64'd0;
          r_a_err   <= ~w_in_range;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (round-robin and fixed priority), each with a negedge-write memory.
// A directed vector table, arbitration, reset and held-request sequences, then randomized traffic against a word model.
module tb_data_mem_arbiter;

  localparam logic [63:0] S       = 64'h1000_0000_0000_0000;
  localparam logic [63:0] NWORDS  = 64'h100;
  localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b1;

  logic        req   [2][2];
  logic        wwe_i [2][2];
  logic        bwe_i [2][2];
  logic [63:0] addr_i[2][2];
  logic [63:0] wd_i  [2][2];
  wire         ack_o [2][2];
  wire         err_o [2][2];
  wire  [63:0] rd_o  [2][2];

  wire  [63:0] m_addr [2];
  wire  [63:0] m_wdata[2];
  wire  [63:0] m_rdata[2];
  wire         m_wwe  [2];
  wire         m_bwe  [2];

  logic [63:0] phys   [2][256];
  logic [63:0] ref_mem[2][256];
  int wwe_cnt[2];
  int bwe_cnt[2];
  int bad_we[2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The segment spans NWORDS*8 bytes from S; 65-bit sums keep addresses near 2^64 from wrapping.
  function automatic bit in_seg(input logic [63:0] a);
    return ({1'b0, a} >= {1'b0, S}) && ({1'b0, a} < ({1'b0, S} + {1'b0, NWORDS} * 65'd8));
  endfunction

  function automatic logic [7:0] widx(input logic [63:0] a);
    return 8'((a - S) >> 3);
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      data_mem_arbiter #(
        .FIXED_PRIO (gi == 1),
        .DATA_START (S),
        .DATA_WORDS (NWORDS)
      ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_req       (req[gi][0]),
        .a_word_we   (wwe_i[gi][0]),
        .a_byte_we   (bwe_i[gi][0]),
        .a_addr      (addr_i[gi][0]),
        .a_wdata     (wd_i[gi][0]),
        .a_ack       (ack_o[gi][0]),
        .a_err       (err_o[gi][0]),
        .a_rdata     (rd_o[gi][0]),
        .b_req       (req[gi][1]),
        .b_word_we   (wwe_i[gi][1]),
        .b_byte_we   (bwe_i[gi][1]),
        .b_addr      (addr_i[gi][1]),
        .b_wdata     (wd_i[gi][1]),
        .b_ack       (ack_o[gi][1]),
        .b_err       (err_o[gi][1]),
        .b_rdata     (rd_o[gi][1]),
        .mem_addr    (m_addr[gi]),
        .mem_wdata   (m_wdata[gi]),
        .mem_word_we (m_wwe[gi]),
        .mem_byte_we (m_bwe[gi]),
        .mem_rdata   (m_rdata[gi])
      );
      assign m_rdata[gi] = in_seg(m_addr[gi]) ? phys[gi][widx(m_addr[gi])] : GARBAGE;
    end
  endgenerate

  // Memory model: combinational read, write on negedge; any enable outside the segment is recorded.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clr) begin
        for (int k = 0; k < 256; k++) phys[d][k] <= '0;
      end else begin
        if (m_wwe[d] || m_bwe[d]) begin
          if (!in_seg(m_addr[d]) || (m_wwe[d] && m_bwe[d])) bad_we[d] <= bad_we[d] + 1;
          else if (m_wwe[d]) phys[d][widx(m_addr[d])] <= m_wdata[d];
          else phys[d][widx(m_addr[d])][{m_addr[d][2:0], 3'b000} +: 8] <= m_wdata[d][7:0];
        end
        if (m_wwe[d]) wwe_cnt[d] <= wwe_cnt[d] + 1;
        if (m_bwe[d]) bwe_cnt[d] <= bwe_cnt[d] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: updates the word image and returns the err/rdata a completed access should report.
  task automatic model(input int d, input logic ww, input logic bw, input logic [63:0] ad,
                       input logic [63:0] wd, output logic e, output logic [63:0] rd);
    logic [7:0] i;
    if (!in_seg(ad)) begin
      e = 1'b1;
      rd = 64'd0;
    end else begin
      i = widx(ad);
      if (ww) ref_mem[d][i] = wd;
      else if (bw) ref_mem[d][i][{ad[2:0], 3'b000} +: 8] = wd[7:0];
      e = 1'b0;
      rd = ref_mem[d][i];
    end
  endtask

  task automatic do_access(input int d, input int p, input logic ww, input logic bw,
                           input logic [63:0] ad, input logic [63:0] wd,
                           output bit got, output int lat, output logic e, output logic [63:0] rd);
    @(posedge clk); #1;
    wwe_i[d][p] = ww;
    bwe_i[d][p] = bw;
    addr_i[d][p] = ad;
    wd_i[d][p] = wd;
    req[d][p] = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      got = ack_o[d][p];
    end
    e = err_o[d][p];
    rd = rd_o[d][p];
    req[d][p] = 1'b0;
    $display("txn dut%0d port %s ww=%0b bw=%0b addr=%h wdata=%h -> ack=%0b lat=%0d err=%0b rdata=%h",
             d, (p == 0) ? "A" : "B", ww, bw, ad, wd, got, lat, e, rd);
  endtask

  // Both ports request reads and hold them; records the port of each of the first four acks (bit = 1 for B).
  task automatic both_hold(input int d, output logic [3:0] seq, output int cnt);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      wwe_i[d][p] = 1'b0;
      bwe_i[d][p] = 1'b0;
      addr_i[d][p] = S;
      req[d][p] = 1'b1;
    end
    cnt = 0;
    seq = '0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(posedge clk); #1;
      if (ack_o[d][0] || ack_o[d][1]) begin
        seq[cnt] = ack_o[d][1];
        cnt++;
      end
    end
  endtask

  task automatic rand_port(input int p);
    bit got;
    int lat;
    int op;
    int r;
    logic ww, bw, e, exp_e;
    logic [63:0] ad, wd, rd, exp_rd;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      ww = (op == 1) || (op == 3);
      bw = (op >= 2);
      r = $urandom_range(0, 9);
      if (r == 0) ad = S - 64'(8 * $urandom_range(1, 4));
      else if (r == 1) ad = S + 64'h800 + 64'($urandom_range(0, 15));
      else if (r == 2) ad = 64'hFFFF_FFFF_FFFF_FFF8 - 64'(8 * $urandom_range(0, 3));
      else ad = S + 64'(p * 'h400) + 64'($urandom_range(0, 'h3FF));
      wd = {$urandom, $urandom};
      do_access(0, p, ww, bw, ad, wd, got, lat, e, rd);
      model(0, ww, bw, ad, wd, exp_e, exp_rd);
      chk($sformatf("rand p%0d #%0d ack", p, n), 64'(got), 64'd1);
      chk($sformatf("rand p%0d #%0d err", p, n), 64'(e), 64'(exp_e));
      chk($sformatf("rand p%0d #%0d rdata", p, n), rd, exp_rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  typedef struct {
    int          port;
    logic        ww;
    logic        bw;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rd;
    int          exp_wwe;
    int          exp_bwe;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int lat;
    int cnt;
    int w0, b0;
    int c1, c2;
    int mism;
    logic e, me;
    logic [63:0] rd, mrd;
    logic [3:0] seq;

    vecs[0]  = '{0, 1'b1, 1'b0, S + 64'h8,   64'h1122_3344_5566_7788, 1'b0, 64'h1122_3344_5566_7788, 1, 0};
    vecs[1]  = '{0, 1'b0, 1'b0, S + 64'h8,   64'h0,                   1'b0, 64'h1122_3344_5566_7788, 0, 0};
    vecs[2]  = '{1, 1'b1, 1'b0, S + 64'h10,  64'h0102_0304_0506_0708, 1'b0, 64'h0102_0304_0506_0708, 1, 0};
    vecs[3]  = '{1, 1'b0, 1'b1, S + 64'h13,  64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 64'h0102_0304_AB06_0708, 0, 1};
    vecs[4]  = '{0, 1'b1, 1'b1, S + 64'h1B,  64'hCAFE_BABE_0000_0055, 1'b0, 64'hCAFE_BABE_0000_0055, 1, 0};
    vecs[5]  = '{0, 1'b0, 1'b0, S - 64'h8,   64'h0,                   1'b1, 64'h0,                   0, 0};
    vecs[6]  = '{1, 1'b1, 1'b0, S + 64'h800, 64'h1,                   1'b1, 64'h0,                   0, 0};
    vecs[7]  = '{0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h2,       1'b1, 64'h0,                   0, 0};
    vecs[8]  = '{1, 1'b0, 1'b1, S + 64'h7FF, 64'h5A,                  1'b0, 64'h5A00_0000_0000_0000, 0, 1};
    vecs[9]  = '{0, 1'b0, 1'b0, S + 64'h7F8, 64'h0,                   1'b0, 64'h5A00_0000_0000_0000, 0, 0};
    vecs[10] = '{0, 1'b0, 1'b0, S + 64'h18,  64'h0,                   1'b0, 64'hCAFE_BABE_0000_0055, 0, 0};
    vecs[11] = '{1, 1'b0, 1'b0, S + 64'h10,  64'h0,                   1'b0, 64'h0102_0304_AB06_0708, 0, 0};

    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        wwe_i[d][p] = 1'b0;
        bwe_i[d][p] = 1'b0;
        addr_i[d][p] = '0;
        wd_i[d][p] = '0;
      end
      for (int k = 0; k < 256; k++) ref_mem[d][k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_clr = 1'b0;

    // State right after reset
    chk("reset a_ack", 64'(ack_o[0][0]), 64'd0);
    chk("reset b_ack", 64'(ack_o[0][1]), 64'd0);
    chk("reset a_err", 64'(err_o[0][0]), 64'd0);
    chk("reset b_rdata", rd_o[0][1], 64'd0);
    chk("reset mem_we", 64'({m_wwe[0], m_bwe[0]}), 64'd0);
    chk("reset mem_addr", m_addr[0], 64'd0);
    chk("reset mem_wdata", m_wdata[0], 64'd0);

    // Directed vectors on the round-robin instance, one port at a time
    for (int i = 0; i < 12; i++) begin
      w0 = wwe_cnt[0];
      b0 = bwe_cnt[0];
      do_access(0, vecs[i].port, vecs[i].ww, vecs[i].bw, vecs[i].addr, vecs[i].wdata, got, lat, e, rd);
      model(0, vecs[i].ww, vecs[i].bw, vecs[i].addr, vecs[i].wdata, me, mrd);
      chk($sformatf("vec%0d ack", i), 64'(got), 64'd1);
      chk($sformatf("vec%0d ack latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d err", i), 64'(e), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d word_we cycles", i), 64'(wwe_cnt[0] - w0), 64'(vecs[i].exp_wwe));
      chk($sformatf("vec%0d byte_we cycles", i), 64'(bwe_cnt[0] - b0), 64'(vecs[i].exp_bwe));
    end

    // Round-robin: last grant was B (vector 11), so held ties alternate A,B,A,B
    both_hold(0, seq, cnt);
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("rr grant count", 64'(cnt), 64'd4);
    chk("rr grant order", 64'(seq), 64'b1010);

    // Fixed priority: A held starves B; B is served once A drops
    both_hold(1, seq, cnt);
    req[1][0] = 1'b0;
    chk("fixed grant count", 64'(cnt), 64'd4);
    chk("fixed grant order", 64'(seq), 64'b0000);
    got = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk); #1;
      got = ack_o[1][1];
      if (ack_o[1][0]) cnt++;
    end
    req[1][1] = 1'b0;
    chk("fixed B served after A idles", 64'(got), 64'd1);
    chk("fixed no A ack after drop", 64'(cnt), 64'd0);

    // Request held through the ack: a second access follows, one ack pulse each
    @(posedge clk); #1;
    wwe_i[0][0] = 1'b0;
    bwe_i[0][0] = 1'b0;
    addr_i[0][0] = S + 64'h8;
    req[0][0] = 1'b1;
    c1 = -1;
    c2 = -1;
    cnt = 0;
    for (int c = 1; c < 20 && c2 < 0; c++) begin
      @(posedge clk); #1;
      if (ack_o[0][0]) begin
        cnt++;
        chk("held rdata", rd_o[0][0], 64'h1122_3344_5566_7788);
        if (c1 < 0) c1 = c;
        else c2 = c;
      end
    end
    req[0][0] = 1'b0;
    chk("held first ack cycle", 64'(c1), 64'd2);
    chk("held ack spacing", 64'(c2 - c1), 64'd3);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack_o[0][0] || ack_o[0][1]) cnt++;
    end
    chk("held no extra acks", 64'(cnt), 64'd0);

    // Reset during SERVE of an A write; last grant before reset was A
    @(posedge clk); #1;
    wwe_i[0][0] = 1'b1;
    addr_i[0][0] = S + 64'h20;
    wd_i[0][0] = 64'h0BAD_F00D_0BAD_F00D;
    req[0][0] = 1'b1;
    @(posedge clk); #1;
    chk("serve word_we before reset", 64'(m_wwe[0]), 64'd1);
    reset = 1'b1;
    req[0][0] = 1'b0;
    wwe_i[0][0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // The memory wrote at the SERVE negedge, before reset was sampled.
    ref_mem[0][4] = 64'h0BAD_F00D_0BAD_F00D;
    chk("post-reset word_we", 64'(m_wwe[0]), 64'd0);
    chk("post-reset a_rdata cleared", rd_o[0][0], 64'd0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (ack_o[0][0] || ack_o[0][1]) cnt++;
      @(posedge clk); #1;
    end
    chk("no ack for dropped access", 64'(cnt), 64'd0);
    both_hold(0, seq, cnt);
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("post-reset first tie to A", 64'(seq[0]), 64'd0);
    chk("post-reset rr order", 64'(seq), 64'b1010);

    // Randomized concurrent traffic; each port works in its own half of the segment
    fork
      rand_port(0);
      rand_port(1);
    join

    repeat (3) @(posedge clk);
    #1;
    chk("dut0 illegal we", 64'(bad_we[0]), 64'd0);
    chk("dut1 illegal we", 64'(bad_we[1]), 64'd0);
    mism = 0;
    for (int k = 0; k < 256; k++) begin
      if (phys[0][k] !== ref_mem[0][k]) mism++;
    end
    chk("memory image words differing", 64'(mism), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
